fetch_unit: RTL and testbench

IF stage of the pipelined core: owns the PC, issues instruction-memory requests over a valid/ready handshake, and drives the IF/ID pipeline register consumed by ID.
- Honours the load-use `stall` from the ID hazard unit by holding IF/ID.
- Honours `flush`/redirect from EX on taken branches and jumps.
- A one-entry hold buffer absorbs a response that arrives while IF/ID is stalled.

---
 rtl/fetch_unit.sv | 158 +++++++++++++++
 tb/tb_fetch_unit.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// IF stage: owns the PC, fetches over a valid/ready imem port and drives the IF/ID register.
// Optional performance counters are enabled with `define FETCH_PERF_CNT_EN.
module fetch_unit #(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            flush,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [31:0]     imem_resp_data,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]     perf_stall_cycles,
  output logic [31:0]     perf_flush_count,
`endif
  output logic [XLEN-1:0] pc_IFID,
  output logic [31:0]     instr_IFID,
  output logic            valid_IFID
);

  typedef enum logic [1:0] {StReq, StWait, StHold, StDrain} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic [XLEN-1:0] pc_ifid_q, pc_ifid_d;
  logic [31:0]     instr_ifid_q, instr_ifid_d;
  logic            valid_ifid_q, valid_ifid_d;
  logic [XLEN-1:0] hold_pc_q, hold_pc_d;
  logic [31:0]     hold_instr_q, hold_instr_d;
  logic            hold_valid_q, hold_valid_d;
  logic            req_fire;
  logic            ifid_free;

  // Flush kills any request in the same cycle so the stale PC never reaches memory.
  assign imem_req_valid = (state_q == StReq) && !reset && !flush;
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign ifid_free      = !stall || !valid_ifid_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    req_pc_d     = req_pc_q;
    pc_ifid_d    = pc_ifid_q;
    instr_ifid_d = instr_ifid_q;
    valid_ifid_d = valid_ifid_q;
    hold_pc_d    = hold_pc_q;
    hold_instr_d = hold_instr_q;
    hold_valid_d = hold_valid_q;

    if (flush) begin
      pc_d         = redirect_pc;
      valid_ifid_d = 1'b0;
      instr_ifid_d = NOP_INSTR;
      hold_valid_d = 1'b0;
      unique case (state_q)
        StReq:   state_d = StReq;
        StWait:  state_d = imem_resp_valid ? StReq : StDrain;
        StHold:  state_d = StReq;
        StDrain: state_d = imem_resp_valid ? StReq : StDrain;
        default: state_d = StReq;
      endcase
    end else begin
      unique case (state_q)
        StReq: begin
          if (req_fire) begin
            req_pc_d = pc_q;
            pc_d     = pc_q + XLEN'(4);
            state_d  = StWait;
          end
        end
        StWait: begin
          if (imem_resp_valid) begin
            if (ifid_free) begin
              pc_ifid_d    = req_pc_q;
              instr_ifid_d = imem_resp_data;
              valid_ifid_d = 1'b1;
              state_d      = StReq;
            end else begin
              hold_pc_d    = req_pc_q;
              hold_instr_d = imem_resp_data;
              hold_valid_d = 1'b1;
              state_d      = StHold;
            end
          end
        end
        StHold: begin
          if (!stall) begin
            pc_ifid_d    = hold_pc_q;
            instr_ifid_d = hold_instr_q;
            valid_ifid_d = 1'b1;
            hold_valid_d = 1'b0;
            state_d      = StReq;
          end
        end
        StDrain: begin
          if (imem_resp_valid) begin
            state_d = StReq;
          end
        end
        default: state_d = StReq;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StReq;
      pc_q         <= RESET_PC;
      req_pc_q     <= '0;
      pc_ifid_q    <= '0;
      instr_ifid_q <= NOP_INSTR;
      valid_ifid_q <= 1'b0;
      hold_pc_q    <= '0;
      hold_instr_q <= NOP_INSTR;
      hold_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_pc_q     <= req_pc_d;
      pc_ifid_q    <= pc_ifid_d;
      instr_ifid_q <= instr_ifid_d;
      valid_ifid_q <= valid_ifid_d;
      hold_pc_q    <= hold_pc_d;
      hold_instr_q <= hold_instr_d;
      hold_valid_q <= hold_valid_d;
    end
  end

  assign pc_IFID    = pc_ifid_q;
  assign instr_IFID = instr_ifid_q;
  assign valid_IFID = valid_ifid_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall && valid_ifid_q) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (flush)                 flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign perf_stall_cycles = stall_cnt_q;
  assign perf_flush_count  = flush_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit; the memory side is driven cycle by cycle.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset, stall, flush;
  logic [31:0] redirect_pc;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic [31:0] pc_IFID, instr_IFID;
  logic        valid_IFID;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_stall_cycles, perf_flush_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .flush           (flush),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
`ifdef FETCH_PERF_CNT_EN
    .perf_stall_cycles (perf_stall_cycles),
    .perf_flush_count  (perf_flush_count),
`endif
    .pc_IFID         (pc_IFID),
    .instr_IFID      (instr_IFID),
    .valid_IFID      (valid_IFID)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs are then driven and sampled mid-cycle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check_ifid(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                            input logic vld);
    check_val({tag, "_pc"}, pc_IFID, pc);
    check_val({tag, "_instr"}, instr_IFID, instr);
    check_val({tag, "_valid"}, {31'd0, valid_IFID}, {31'd0, vld});
  endtask

  task automatic check_req(input string tag, input logic vld, input logic [31:0] addr);
    check_val({tag, "_req_valid"}, {31'd0, imem_req_valid}, {31'd0, vld});
    if (vld) check_val({tag, "_req_addr"}, imem_req_addr, addr);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0; redirect_pc = '0;
    imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0;
    step(); step();
    check_req("in_reset", 1'b0, 32'h0);
    reset = 1'b0; settle();
    check_ifid("reset", 32'h0, 32'h0000_0013, 1'b0);
    check_req("reset", 1'b1, 32'h0);

    // Zero-wait fetch of two words
    imem_req_ready = 1'b1;
    step();
    check_req("t1_wait", 1'b0, 32'h0);
    imem_resp_valid = 1'b1; imem_resp_data = 32'h0050_0093;
    step();
    imem_resp_valid = 1'b0; settle();
    check_ifid("t1_first", 32'h0, 32'h0050_0093, 1'b1);
    check_req("t1_first", 1'b1, 32'h4);
    step();
    imem_resp_valid = 1'b1; imem_resp_data = 32'h00a0_0113;
    step();
    imem_resp_valid = 1'b0; settle();
    check_ifid("t1_second", 32'h4, 32'h00a0_0113, 1'b1);
    check_req("t1_second", 1'b1, 32'h8);

    // Stall while the 0x8 response arrives: it lands in the hold buffer
    stall = 1'b1;
    step();
    imem_resp_valid = 1'b1; imem_resp_data = 32'h0020_81b3;
    step();
    imem_resp_valid = 1'b0; settle();
    check_ifid("t2_hold1", 32'h4, 32'h00a0_0113, 1'b1);
    check_req("t2_hold1", 1'b0, 32'h0);
    step();
    check_ifid("t2_hold2", 32'h4, 32'h00a0_0113, 1'b1);
    check_req("t2_hold2", 1'b0, 32'h0);
    stall = 1'b0;
    step();
    check_ifid("t2_release", 32'h8, 32'h0020_81b3, 1'b1);
    check_req("t2_release", 1'b1, 32'hc);

    // Flush in WAIT, response two cycles later is dropped
    step();
    flush = 1'b1; redirect_pc = 32'h100;
    step();
    flush = 1'b0; settle();
    check_ifid("t3_flush", 32'h8, 32'h0000_0013, 1'b0);
    check_req("t3_drain1", 1'b0, 32'h0);
    step();
    check_req("t3_drain2", 1'b0, 32'h0);
    imem_resp_valid = 1'b1; imem_resp_data = 32'hdead_beef;
    step();
    imem_resp_valid = 1'b0; settle();
    check_ifid("t3_dropped", 32'h8, 32'h0000_0013, 1'b0);
    check_req("t3_redirect", 1'b1, 32'h100);

    // Flush together with stall while in HOLD
    step();
    imem_resp_valid = 1'b1; imem_resp_data = 32'h1111_1111;
    step();
    imem_resp_valid = 1'b0; settle();
    check_ifid("t4_fill", 32'h100, 32'h1111_1111, 1'b1);
    stall = 1'b1;
    step();
    imem_resp_valid = 1'b1; imem_resp_data = 32'h2222_2222;
    step();
    imem_resp_valid = 1'b0; settle();
    check_req("t4_hold", 1'b0, 32'h0);
    flush = 1'b1; redirect_pc = 32'h200; settle();
    check_req("t4_flush_cycle", 1'b0, 32'h0);
    step();
    flush = 1'b0; stall = 1'b0; imem_req_ready = 1'b0; settle();
    check_ifid("t4_flushed", 32'h100, 32'h0000_0013, 1'b0);
    check_req("t4_redirect", 1'b1, 32'h200);
    step();
    check_ifid("t4_no_hold_leak", 32'h100, 32'h0000_0013, 1'b0);

    // Flush in REQ suppresses the request; then PC wraps at the top of memory
    imem_req_ready = 1'b1; flush = 1'b1; redirect_pc = 32'hffff_fffc; settle();
    check_req("t5_flush_req", 1'b0, 32'h0);
    step();
    flush = 1'b0; settle();
    check_req("t5_top", 1'b1, 32'hffff_fffc);
    step();
    imem_resp_valid = 1'b1; imem_resp_data = 32'h0000_0033;
    step();
    imem_resp_valid = 1'b0; settle();
    check_ifid("t5_wrap", 32'hffff_fffc, 32'h0000_0033, 1'b1);
    check_req("t5_wrap", 1'b1, 32'h0);

`ifdef FETCH_PERF_CNT_EN
    // Stall&valid edges: 3 in the HOLD test, 3 in the flush-in-HOLD test; flushes: 3
    check_val("perf_stall", perf_stall_cycles, 32'd6);
    check_val("perf_flush", perf_flush_count, 32'd3);
`endif

    // Reset mid-transaction: the stale response must be ignored
    step();
    reset = 1'b1;
    step();
    reset = 1'b0; imem_req_ready = 1'b0; imem_resp_valid = 1'b1; imem_resp_data = 32'h5555_5555;
    settle();
`ifdef FETCH_PERF_CNT_EN
    check_val("perf_stall_rst", perf_stall_cycles, 32'd0);
    check_val("perf_flush_rst", perf_flush_count, 32'd0);
`endif
    step();
    imem_resp_valid = 1'b0; settle();
    check_ifid("rst_mid", 32'h0, 32'h0000_0013, 1'b0);
    check_req("rst_mid", 1'b1, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
